// File: rtl/axis_video_pkg.sv
// Shared types and constants for the AXI4-Stream video frame sink.
// The tready throttle LFSR defined here is only used when AXIS_SINK_THROTTLE_EN is defined.
package axis_video_pkg;

  localparam int RGB_CHANNELS = 3;
  localparam int CHANNEL_W    = 8;
  localparam int PIXEL_W      = RGB_CHANNELS * CHANNEL_W;
  localparam int CHECKSUM_W   = 32;
  localparam int LFSR_W       = 16;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic sof_early;
    logic eol_early;
    logic eol_missing;
  } frame_status_t;

  // One shift of the Fibonacci LFSR: feedback is the parity of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] value);
    return {value[LFSR_W-2:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_tready_lfsr.sv
// Pseudo-random enable generator used to throttle s_axis_tready.
// Instantiated by the sink only when AXIS_SINK_THROTTLE_EN is defined.
module axis_tready_lfsr
  import axis_video_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  logic [LFSR_W-1:0] lfsr;

  // Free-running LFSR, stepping every cycle from the seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign en = lfsr[0];

endmodule

// File: rtl/axis_video_frame_sink.sv
// AXI4-Stream 24-bit RGB video sink: tracks row/col, checks framing against the
// geometry latched at SOF, forwards pixels with coordinates and reports a
// per-frame checksum and status.
// Optional build macro AXIS_SINK_THROTTLE_EN: pseudo-random backpressure on tready.
module axis_video_frame_sink
  import axis_video_pkg::*;
#(
  parameter int                C_S_AXIS_TDATA_WIDTH = 24,
  parameter int                DIM_W                = 16,
  parameter logic [LFSR_W-1:0] THROTTLE_SEED        = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tuser,
  output logic                            s_axis_tready,
  input  logic [DIM_W-1:0]                cfg_cols,
  input  logic [DIM_W-1:0]                cfg_rows,
  output logic                            pix_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] pix_data,
  output logic [DIM_W-1:0]                pix_row,
  output logic [DIM_W-1:0]                pix_col,
  output logic                            frame_done,
  output logic [CHECKSUM_W-1:0]           frame_checksum,
  output logic [2:0]                      frame_status,
  output logic [15:0]                     frame_count,
  output logic [15:0]                     drop_count
);

  localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

  state_t                  state, state_next;
  logic [DIM_W-1:0]        row_q, col_q, cols_q, rows_q;
  logic [CHECKSUM_W-1:0]   acc_q;
  frame_status_t           status_q;

  logic                    accept;
  logic                    beat_pix, beat_start, beat_restart, beat_drop, last_pix;
  logic                    eol, eol_early, eol_missing;
  logic [DIM_W-1:0]        eff_cols, eff_rows, cur_row, cur_col, row_next, col_next;
  logic [CHECKSUM_W-1:0]   beat_ext, sum_next;
  frame_status_t           status_next;

`ifdef AXIS_SINK_THROTTLE_EN
  logic throttle_en;

  axis_tready_lfsr #(
    .SEED (THROTTLE_SEED)
  ) u_tready_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (throttle_en)
  );

  assign s_axis_tready = ~reset & throttle_en;
`else
  assign s_axis_tready = ~reset;
`endif

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign beat_ext = {{(CHECKSUM_W-C_S_AXIS_TDATA_WIDTH){1'b0}}, s_axis_tdata};

  // State register for the framing FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_next;
    end
  end

  // Classify the accepted beat, locate it in the frame and derive the next position, checksum and status
  always_comb begin
    state_next   = state;
    beat_pix     = 1'b0;
    beat_start   = 1'b0;
    beat_restart = 1'b0;
    beat_drop    = 1'b0;
    last_pix     = 1'b0;
    eol          = 1'b0;
    eol_early    = 1'b0;
    eol_missing  = 1'b0;
    eff_cols     = cols_q;
    eff_rows     = rows_q;
    cur_row      = row_q;
    cur_col      = col_q;
    row_next     = row_q;
    col_next     = col_q;
    sum_next     = acc_q;
    status_next  = status_q;

    case (state)
      WAIT_SOF: begin
        if (accept) begin
          if (s_axis_tuser && (cfg_cols != '0) && (cfg_rows != '0)) begin
            beat_pix   = 1'b1;
            beat_start = 1'b1;
            eff_cols   = cfg_cols;
            eff_rows   = cfg_rows;
            cur_row    = '0;
            cur_col    = '0;
          end else begin
            beat_drop  = 1'b1;
          end
        end
      end
      IN_FRAME: begin
        if (accept) begin
          beat_pix = 1'b1;
          if (s_axis_tuser) begin
            beat_restart = 1'b1;
            cur_row      = '0;
            cur_col      = '0;
          end
        end
      end
      default: state_next = WAIT_SOF;
    endcase

    if (beat_pix) begin
      eol         = s_axis_tlast || (cur_col == eff_cols - DIM_ONE);
      eol_early   = s_axis_tlast && (cur_col != eff_cols - DIM_ONE);
      eol_missing = !s_axis_tlast && (cur_col == eff_cols - DIM_ONE);
      last_pix    = eol && (cur_row == eff_rows - DIM_ONE) && !beat_restart;

      status_next             = beat_start ? frame_status_t'('0) : status_q;
      status_next.sof_early   = status_next.sof_early | beat_restart;
      status_next.eol_early   = status_next.eol_early | eol_early;
      status_next.eol_missing = status_next.eol_missing | eol_missing;

      sum_next = (beat_start || beat_restart) ? beat_ext : acc_q + beat_ext;

      if (eol) begin
        col_next = '0;
        row_next = (cur_row == eff_rows - DIM_ONE) ? '0 : cur_row + DIM_ONE;
      end else begin
        col_next = cur_col + DIM_ONE;
        row_next = cur_row;
      end

      state_next = last_pix ? WAIT_SOF : IN_FRAME;
    end
  end

  // Frame tracking registers: position, latched geometry, running checksum and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      col_q    <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      acc_q    <= '0;
      status_q <= '0;
    end else if (beat_pix) begin
      row_q    <= row_next;
      col_q    <= col_next;
      acc_q    <= sum_next;
      status_q <= status_next;
      if (beat_start) begin
        cols_q <= cfg_cols;
        rows_q <= cfg_rows;
      end
    end
  end

  // Registered pixel forwarding with coordinates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
    end else begin
      pix_valid <= beat_pix;
      if (beat_pix) begin
        pix_data <= s_axis_tdata;
        pix_row  <= cur_row;
        pix_col  <= cur_col;
      end
    end
  end

  // Per-frame report, held until the next completed frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done     <= 1'b0;
      frame_checksum <= '0;
      frame_status   <= '0;
      frame_count    <= '0;
    end else begin
      frame_done <= last_pix;
      if (last_pix) begin
        frame_checksum <= sum_next;
        frame_status   <= status_next;
        frame_count    <= frame_count + 16'd1;
      end
    end
  end

  // Saturating count of beats discarded while waiting for SOF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (beat_drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_video_frame_sink.sv
// Directed testbench for axis_video_frame_sink with hand-computed expectations.
module tb_axis_video_frame_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tready;
  logic [15:0] cfg_cols = 16'd4;
  logic [15:0] cfg_rows = 16'd3;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [15:0] pix_row, pix_col;
  logic        frame_done;
  logic [31:0] frame_checksum;
  logic [2:0]  frame_status;
  logic [15:0] frame_count, drop_count;

  int n_vec = 0;
  int n_err = 0;

  axis_video_frame_sink dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tready  (s_axis_tready),
    .cfg_cols       (cfg_cols),
    .cfg_rows       (cfg_rows),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_row        (pix_row),
    .pix_col        (pix_col),
    .frame_done     (frame_done),
    .frame_checksum (frame_checksum),
    .frame_status   (frame_status),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  // Drive one beat from the falling edge, wait (bounded) for tready, sample 1 ns after the accepting edge
  task automatic send_beat(input logic [23:0] data, input logic user, input logic last);
    int waited = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    while (!s_axis_tready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!s_axis_tready) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL tready_timeout: tready=%0b after %0d cycles, required 1", s_axis_tready, waited);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_vec++;
    if ({s_axis_tready, pix_valid, frame_done, frame_count, drop_count, frame_checksum, frame_status} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: tready=%0b pix_valid=%0b done=%0b fc=%0d dc=%0d sum=%h st=%b, required all 0",
               s_axis_tready, pix_valid, frame_done, frame_count, drop_count, frame_checksum, frame_status);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (s_axis_tready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ready_after_reset: tready=%0b, required 1", s_axis_tready);
    end
  endtask

  // Clean 4x3 frame with pixels 1..12; checks every pixel and the frame report
  task automatic run_clean_frame(input string name, input logic [15:0] exp_count);
    cfg_cols = 16'd4;
    cfg_rows = 16'd3;
    for (int i = 0; i < 12; i++) begin
      send_beat(24'(i + 1), i == 0, (i % 4) == 3);
      n_vec++;
      if (pix_valid !== 1'b1 || pix_data !== 24'(i + 1) || pix_row !== 16'(i / 4) || pix_col !== 16'(i % 4)
          || frame_done !== (i == 11)) begin
        n_err++;
        $display("[TB] FAIL %s_pix%0d: v=%0b d=%h r=%0d c=%0d done=%0b, required v=1 d=%h r=%0d c=%0d done=%0b",
                 name, i, pix_valid, pix_data, pix_row, pix_col, frame_done, 24'(i + 1), i / 4, i % 4, i == 11);
      end
    end
    n_vec++;
    if (frame_checksum !== 32'h4E || frame_status !== 3'b000 || frame_count !== exp_count) begin
      n_err++;
      $display("[TB] FAIL %s_report: sum=%h st=%b fc=%0d, required sum=0000004e st=000 fc=%0d",
               name, frame_checksum, frame_status, frame_count, exp_count);
    end
    idle_cycle();
    n_vec++;
    if (frame_done !== 1'b0 || pix_valid !== 1'b0 || frame_checksum !== 32'h4E) begin
      n_err++;
      $display("[TB] FAIL %s_after: done=%0b pix_valid=%0b sum=%h, required 0 0 0000004e",
               name, frame_done, pix_valid, frame_checksum);
    end
  endtask

  task automatic test_clean_frame();
    run_clean_frame("clean", 16'd1);
  endtask

  task automatic test_drop_before_sof();
    for (int i = 0; i < 5; i++) begin
      send_beat(24'h000100 + 24'(i), 1'b0, 1'b0);
      n_vec++;
      if (pix_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL drop_pix%0d: pix_valid=%0b, required 0", i, pix_valid);
      end
    end
    n_vec++;
    if (drop_count !== 16'd5) begin
      n_err++;
      $display("[TB] FAIL drop_count: got %0d, required 5", drop_count);
    end
    run_clean_frame("after_drop", 16'd2);
  endtask

  // Row 1 ends early after 3 pixels: 11 beats total, status eol_early
  task automatic test_eol_early();
    int idx = 0;
    logic [15:0] rr [11];
    logic [15:0] cc [11];
    logic        ll [11];
    for (int i = 0; i < 11; i++) begin
      rr[i] = (i < 4) ? 16'd0 : (i < 7) ? 16'd1 : 16'd2;
      cc[i] = (i < 4) ? 16'(i) : (i < 7) ? 16'(i - 4) : 16'(i - 7);
      ll[i] = (i == 3) || (i == 6) || (i == 10);
    end
    for (int i = 0; i < 11; i++) begin
      send_beat(24'(i + 1), i == 0, ll[i]);
      idx = i;
      n_vec++;
      if (pix_valid !== 1'b1 || pix_row !== rr[idx] || pix_col !== cc[idx] || frame_done !== (i == 10)) begin
        n_err++;
        $display("[TB] FAIL eol_early_pix%0d: v=%0b r=%0d c=%0d done=%0b, required v=1 r=%0d c=%0d done=%0b",
                 i, pix_valid, pix_row, pix_col, frame_done, rr[idx], cc[idx], i == 10);
      end
    end
    n_vec++;
    if (frame_status !== 3'b010 || frame_checksum !== 32'h42 || frame_count !== 16'd3) begin
      n_err++;
      $display("[TB] FAIL eol_early_report: st=%b sum=%h fc=%0d, required st=010 sum=00000042 fc=3",
               frame_status, frame_checksum, frame_count);
    end
  endtask

  // Row 0 has no tlast on its 4th pixel: the line still ends, status eol_missing
  task automatic test_eol_missing();
    for (int i = 0; i < 12; i++) begin
      send_beat(24'(i + 1), i == 0, (i == 7) || (i == 11));
      n_vec++;
      if (pix_valid !== 1'b1 || pix_row !== 16'(i / 4) || pix_col !== 16'(i % 4) || frame_done !== (i == 11)) begin
        n_err++;
        $display("[TB] FAIL eol_missing_pix%0d: v=%0b r=%0d c=%0d done=%0b, required v=1 r=%0d c=%0d done=%0b",
                 i, pix_valid, pix_row, pix_col, frame_done, i / 4, i % 4, i == 11);
      end
    end
    n_vec++;
    if (frame_status !== 3'b001 || frame_checksum !== 32'h4E || frame_count !== 16'd4) begin
      n_err++;
      $display("[TB] FAIL eol_missing_report: st=%b sum=%h fc=%0d, required st=001 sum=0000004e fc=4",
               frame_status, frame_checksum, frame_count);
    end
  endtask

  // SOF on beat 6 restarts at (0,0); the restarted frame has 12 beats of data 1..12
  task automatic test_sof_early();
    for (int i = 0; i < 5; i++) begin
      send_beat(24'h000010 + 24'(i), i == 0, i == 3);
      n_vec++;
      if (pix_row !== 16'(i / 4) || pix_col !== 16'(i % 4) || frame_done !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL sof_early_pre%0d: r=%0d c=%0d done=%0b, required r=%0d c=%0d done=0",
                 i, pix_row, pix_col, frame_done, i / 4, i % 4);
      end
    end
    for (int i = 0; i < 12; i++) begin
      send_beat(24'(i + 1), i == 0, (i % 4) == 3);
      n_vec++;
      if (pix_valid !== 1'b1 || pix_data !== 24'(i + 1) || pix_row !== 16'(i / 4) || pix_col !== 16'(i % 4)
          || frame_done !== (i == 11)) begin
        n_err++;
        $display("[TB] FAIL sof_early_pix%0d: v=%0b d=%h r=%0d c=%0d done=%0b, required v=1 d=%h r=%0d c=%0d done=%0b",
                 i, pix_valid, pix_data, pix_row, pix_col, frame_done, 24'(i + 1), i / 4, i % 4, i == 11);
      end
    end
    n_vec++;
    if (frame_status !== 3'b100 || frame_checksum !== 32'h4E || frame_count !== 16'd5) begin
      n_err++;
      $display("[TB] FAIL sof_early_report: st=%b sum=%h fc=%0d, required st=100 sum=0000004e fc=5",
               frame_status, frame_checksum, frame_count);
    end
  endtask

  // 1x1 frame in one beat, then a zero-geometry SOF which must be dropped
  task automatic test_back_to_back();
    cfg_cols = 16'd1;
    cfg_rows = 16'd1;
    send_beat(24'hABCDEF, 1'b1, 1'b1);
    n_vec++;
    if (pix_valid !== 1'b1 || pix_row !== 16'd0 || pix_col !== 16'd0 || frame_done !== 1'b1
        || frame_status !== 3'b000 || frame_checksum !== 32'h00ABCDEF || frame_count !== 16'd6) begin
      n_err++;
      $display("[TB] FAIL single_beat: v=%0b r=%0d c=%0d done=%0b st=%b sum=%h fc=%0d, required 1 0 0 1 000 00abcdef 6",
               pix_valid, pix_row, pix_col, frame_done, frame_status, frame_checksum, frame_count);
    end
    cfg_cols = 16'd0;
    send_beat(24'h000055, 1'b1, 1'b0);
    n_vec++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0 || drop_count !== 16'd6) begin
      n_err++;
      $display("[TB] FAIL zero_cfg: v=%0b done=%0b dc=%0d, required v=0 done=0 dc=6", pix_valid, frame_done, drop_count);
    end
  endtask

  // Reset after 7 beats of a frame clears outputs at once; the next clean frame counts as frame 1
  task automatic test_reset_mid_frame();
    cfg_cols = 16'd4;
    cfg_rows = 16'd3;
    for (int i = 0; i < 7; i++) begin
      send_beat(24'(i + 1), i == 0, i == 3);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({s_axis_tready, pix_valid, pix_data, frame_done, frame_count, drop_count, frame_checksum} !== '0) begin
      n_err++;
      $display("[TB] FAIL mid_reset: tready=%0b v=%0b d=%h done=%0b fc=%0d dc=%0d sum=%h, required all 0",
               s_axis_tready, pix_valid, pix_data, frame_done, frame_count, drop_count, frame_checksum);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_done: done=%0b, required 0", frame_done);
    end
    run_clean_frame("post_reset", 16'd1);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_clean_frame();
    test_drop_before_sof();
    test_eol_early();
    test_eol_missing();
    test_sof_early();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
